seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 63 ++++++
 rtl/seg_scan_ctrl_bin2bcd_seq.sv | 66 ++++++
 rtl/seg_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared segment codes, reset level and digit helpers
// Holds the segment code defines, the reset-asserted level and the small
// helper functions used by seg_scan_ctrl and bin2bcd_seq. No ports.
`ifndef SEG_SCAN_CTRL_DEFINES
`define SEG_SCAN_CTRL_DEFINES
`define RstEnable 1'b1
`define SEG_0     8'hC0
`define SEG_1     8'hF9
`define SEG_2     8'hA4
`define SEG_3     8'hB0
`define SEG_4     8'h99
`define SEG_5     8'h92
`define SEG_6     8'h82
`define SEG_7     8'hF8
`define SEG_8     8'h80
`define SEG_9     8'h90
`define SEG_A     8'h88
`define SEG_B     8'h83
`define SEG_C     8'hC6
`define SEG_D     8'hA1
`define SEG_E     8'h86
`define SEG_F     8'h8E
`define SEG_BLANK 8'hFF
`define SEG_DASH  8'hBF
`endif

package seg_scan_ctrl_pkg;

  localparam logic       RST_ENABLE = `RstEnable;
  localparam logic [7:0] SEG_OFF    = `SEG_BLANK;
  localparam logic [6:0] GLYPH_BLANK = 7'(`SEG_BLANK);
  localparam logic [6:0] GLYPH_DASH  = 7'(`SEG_DASH);

  // Active-low a..g pattern for one hex nibble; dp is handled by the caller.
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'(`SEG_0);
      4'h1: g = 7'(`SEG_1);
      4'h2: g = 7'(`SEG_2);
      4'h3: g = 7'(`SEG_3);
      4'h4: g = 7'(`SEG_4);
      4'h5: g = 7'(`SEG_5);
      4'h6: g = 7'(`SEG_6);
      4'h7: g = 7'(`SEG_7);
      4'h8: g = 7'(`SEG_8);
      4'h9: g = 7'(`SEG_9);
      4'hA: g = 7'(`SEG_A);
      4'hB: g = 7'(`SEG_B);
      4'hC: g = 7'(`SEG_C);
      4'hD: g = 7'(`SEG_D);
      4'hE: g = 7'(`SEG_E);
      default: g = 7'(`SEG_F);
    endcase
    return g;
  endfunction

  // Double-dabble correction applied to each BCD digit before a shift.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_bin2bcd_seq.sv
// rtl/seg_scan_ctrl_bin2bcd_seq.sv - iterative shift-add-3 binary to BCD converter
// Ports: clk, resetn (sync, active-high), start, bin_in[DATA_W],
//        busy, done (last busy cycle), bcd[4*DIGITS] (result, valid with done),
//        ovf (value needs more than DIGITS digits, valid with done).
module bin2bcd_seq
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DATA_W = 20,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int CW = (DATA_W < 2) ? 1 : $clog2(DATA_W);

  logic [DATA_W-1:0]   shreg;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj;
  logic                ovf_q;
  logic [CW-1:0]       cnt;

  // bcd/ovf are the post-step values, so the caller can commit them on the
  // same edge that ends the conversion.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = bcd_adjust(bcd_q[4*i +: 4]);
    end
    bcd  = {adj[4*DIGITS-2:0], shreg[DATA_W-1]};
    // A one leaving the top digit means the value no longer fits; sticky.
    ovf  = ovf_q | adj[4*DIGITS-1];
    done = busy && (cnt == CW'(DATA_W-1));
  end

  always_ff @(posedge clk) begin
    if (resetn == RST_ENABLE) begin
      busy  <= 1'b0;
      shreg <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt   <= '0;
    end else if (busy) begin
      shreg <= shreg << 1;
      bcd_q <= bcd;
      ovf_q <= ovf;
      cnt   <= cnt + CW'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end else if (start) begin
      shreg <= bin_in;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment display scan controller
// Ports: clk, resetn (sync, active-high), data_in/data_vld/hex_mode/dp_mask/
//        blank_lz (load), busy, overflow, seg_sel (active-low one-hot),
//        seg_control ({dp,g..a}, active-low).
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int DATA_W   = 20,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_vld,
  input  logic              hex_mode,
  input  logic [DIGITS-1:0] dp_mask,
  input  logic              blank_lz,
  output logic              busy,
  output logic              overflow,
  output logic [DIGITS-1:0] seg_sel,
  output logic [7:0]        seg_control
);

  localparam int DIVW = $clog2(SCAN_DIV);
  localparam int IW   = (DIGITS < 2) ? 1 : $clog2(DIGITS);
  localparam int NW   = 4 * DIGITS;
  localparam int EW   = (DATA_W > NW) ? DATA_W : NW;

  logic              load;
  logic              conv_start;
  logic              conv_done;
  logic              conv_ovf;
  logic [NW-1:0]     conv_bcd;

  logic [NW-1:0]     disp_q;
  logic [DIGITS-1:0] dp_q;
  logic [DIGITS-1:0] dp_pend;
  logic              blank_q;
  logic              blank_pend;

  logic [EW-1:0]     data_ext;
  logic              hex_ovf;

  logic [DIVW-1:0]   div_q;
  logic [IW-1:0]     idx_q;
  logic              tick;

  logic [DIGITS-1:0] nz_at_or_above;
  logic              any_nz;
  logic [3:0]        cur_nib;
  logic              cur_dp;
  logic              cur_nz;
  logic [6:0]        cur_glyph;
  logic [7:0]        cur_code;
  logic [DIGITS-1:0] sel_next;

  assign load       = data_vld & ~busy;
  assign conv_start = load & ~hex_mode;

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk    (clk),
    .resetn (resetn),
    .start  (conv_start),
    .bin_in (data_in),
    .busy   (busy),
    .done   (conv_done),
    .bcd    (conv_bcd),
    .ovf    (conv_ovf)
  );

  // Zero-extend so the nibble slice and the out-of-range test work for any
  // DATA_W / DIGITS combination.
  assign data_ext = EW'(data_in);
  assign hex_ovf  = |(data_ext >> NW);

  // Decimal loads park dp/blank settings until the result commits so the
  // display never mixes old digits with new decoration.
  always_ff @(posedge clk) begin
    if (resetn == RST_ENABLE) begin
      disp_q     <= '0;
      overflow   <= 1'b0;
      dp_q       <= '0;
      blank_q    <= 1'b0;
      dp_pend    <= '0;
      blank_pend <= 1'b0;
    end else if (conv_done) begin
      disp_q   <= conv_bcd;
      overflow <= conv_ovf;
      dp_q     <= dp_pend;
      blank_q  <= blank_pend;
    end else if (load) begin
      if (hex_mode) begin
        disp_q   <= data_ext[NW-1:0];
        overflow <= hex_ovf;
        dp_q     <= dp_mask;
        blank_q  <= blank_lz;
      end else begin
        dp_pend    <= dp_mask;
        blank_pend <= blank_lz;
      end
    end
  end

  assign tick = (div_q == DIVW'(SCAN_DIV - 1));

  always_comb begin
    nz_at_or_above = '0;
    any_nz         = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz            = any_nz | (|disp_q[4*i +: 4]);
      nz_at_or_above[i] = any_nz;
    end

    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_nz  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib = disp_q[4*i +: 4];
        cur_dp  = dp_q[i];
        cur_nz  = nz_at_or_above[i];
      end
    end

    if (overflow) begin
      cur_glyph = GLYPH_DASH;
    end else if (blank_q && (idx_q != '0) && !cur_nz) begin
      cur_glyph = GLYPH_BLANK;
    end else begin
      cur_glyph = seg_glyph(cur_nib);
    end

    cur_code = {~cur_dp, cur_glyph};
    sel_next = ~(DIGITS'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (resetn == RST_ENABLE) begin
      div_q       <= '0;
      idx_q       <= '0;
      seg_sel     <= '1;
      seg_control <= SEG_OFF;
    end else begin
      div_q <= tick ? '0 : div_q + DIVW'(1);
      if (tick) begin
        seg_sel     <= sel_next;
        seg_control <= cur_code;
        idx_q       <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [19:0] data_in;
  logic        data_vld;
  logic        hex_mode;
  logic [5:0]  dp_mask;
  logic        blank_lz;
  logic        busy;
  logic        overflow;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_control;

  int total = 0;
  int bad   = 0;
  logic [7:0] frame [6];

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS   (6),
    .DATA_W   (20),
    .SCAN_DIV (4)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .data_in     (data_in),
    .data_vld    (data_vld),
    .hex_mode    (hex_mode),
    .dp_mask     (dp_mask),
    .blank_lz    (blank_lz),
    .busy        (busy),
    .overflow    (overflow),
    .seg_sel     (seg_sel),
    .seg_control (seg_control)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sel_index(input logic [5:0] s);
    int z;
    int k;
    z = 0;
    k = -1;
    for (int i = 0; i < 6; i++) begin
      if (s[i] === 1'b0) begin
        z++;
        k = i;
      end
    end
    return (z == 1) ? k : -1;
  endfunction

  task automatic wait_tick(output int cycles);
    logic [5:0] prev;
    logic       seen;
    prev   = seg_sel;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (seg_sel !== prev) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $error("FAIL tick_timeout observed=%0d cycles expected=tick", cycles);
    end
  endtask

  task automatic conv_wait(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic load(input logic [19:0] v, input logic hx, input logic [5:0] dp, input logic bl);
    data_in  = v;
    hex_mode = hx;
    dp_mask  = dp;
    blank_lz = bl;
    data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
  endtask

  // Sync to one tick (a commit may land mid-frame), then record six ticks.
  task automatic read_frame();
    int cyc;
    int idx;
    int prev;
    for (int i = 0; i < 6; i++) frame[i] = 8'h00;
    wait_tick(cyc);
    prev = sel_index(seg_sel);
    for (int t = 0; t < 6; t++) begin
      wait_tick(cyc);
      idx = sel_index(seg_sel);
      check("tick_period", cyc, 4);
      check("sel_onehot", (idx >= 0) ? 1 : 0, 1);
      check("sel_order", idx, (prev + 1) % 6);
      if (idx >= 0) frame[idx] = seg_control;
      prev = idx;
    end
  endtask

  task automatic check_frame(input string tag, input logic [47:0] exp);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("%s_d%0d", tag, i), {24'h0, frame[i]}, {24'h0, exp[8*i +: 8]});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;

    resetn   = 1'b1;
    data_vld = 1'b0;
    data_in  = '0;
    hex_mode = 1'b0;
    dp_mask  = '0;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_sel", seg_sel, 6'h3F);
    check("rst_seg", seg_control, 8'hFF);
    check("rst_busy", busy, 1'b0);
    check("rst_ovf", overflow, 1'b0);

    resetn = 1'b0;
    wait_tick(cyc);
    check("first_tick_cycles", cyc, 4);
    check("first_tick_sel", seg_sel, 6'h3E);
    check("first_tick_seg", seg_control, 8'hC0);

    // Decimal 123456
    load(20'd123456, 1'b0, 6'b000000, 1'b0);
    check("dec_busy_rise", busy, 1'b1);
    conv_wait(n);
    check("dec_busy_cycles", n, 20);
    check("dec_ovf", overflow, 1'b0);
    read_frame();
    check_frame("dec123456", {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82});

    // Hex ABCDE with leading-zero blanking
    load(20'hABCDE, 1'b1, 6'b000000, 1'b1);
    check("hex_no_busy", busy, 1'b0);
    check("hex_ovf", overflow, 1'b0);
    read_frame();
    check_frame("hexABCDE", {8'hFF, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86});

    // Decimal 1000000 overflows six digits
    load(20'd1000000, 1'b0, 6'b000000, 1'b0);
    conv_wait(n);
    check("ovf_busy_cycles", n, 20);
    check("ovf_flag", overflow, 1'b1);
    read_frame();
    check_frame("ovf", {8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF});

    // Decimal 7 with blanking clears overflow
    load(20'd7, 1'b0, 6'b000000, 1'b1);
    conv_wait(n);
    check("dec7_ovf", overflow, 1'b0);
    read_frame();
    check_frame("dec7", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF8});

    // Decimal 42 with a load of 999 attempted mid-conversion
    load(20'd42, 1'b0, 6'b000010, 1'b0);
    repeat (4) @(negedge clk);
    data_in  = 20'd999;
    data_vld = 1'b1;
    @(negedge clk);
    data_vld = 1'b0;
    conv_wait(n);
    check("ignore_busy_rest", n, 15);
    check("dec42_ovf", overflow, 1'b0);
    read_frame();
    check_frame("dec42", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h19, 8'hA4});

    // Reset in the middle of converting 555
    load(20'd555, 1'b0, 6'b000000, 1'b0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_sel", seg_sel, 6'h3F);
    check("midrst_seg", seg_control, 8'hFF);
    check("midrst_ovf", overflow, 1'b0);
    resetn = 1'b0;
    wait_tick(cyc);
    check("midrst_tick_cycles", cyc, 4);
    check("midrst_tick_sel", seg_sel, 6'h3E);
    check("midrst_tick_seg", seg_control, 8'hC0);
    repeat (30) @(negedge clk);
    check("midrst_no_restart", busy, 1'b0);
    read_frame();
    check_frame("midrst", {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
